icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the decoder's fetch request port and `memctrl`'s instruction-fetch port. Hits are served in one cycle without touching memory. Misses are forwarded to `memctrl`, and the returned instruction and its compressed flag are stored. Entries are keyed on halfword PC (`addr[31:1]`), so RV32C instructions at 2-byte alignment are cached exactly as `memctrl` decodes them.

## Interface
Parameters:
- `INDEX_WIDTH`, default 6: index bits, giving 2^INDEX_WIDTH entries; index = `addr[INDEX_WIDTH:1]`, tag = `addr[31:INDEX_WIDTH+1]`.

Ports (one clock, `clk_in`; reset `rst_in` is synchronous and active-high):
- `clk_in` in 1: system clock.
- `rst_in` in 1: synchronous active-high reset.
- `rdy_in` in 1: global stall; when low, all state and outputs freeze.
- `clear` in 1: misprediction flush from the ROB.
- `if_enable` in 1: decoder fetch request, level; held with a stable `if_addr` until `inst_ready`.
- `if_addr` in 32: fetch PC; bit 0 is always 0.
- `inst_ready` out 1: one-cycle response pulse.
- `inst_val` out 32: instruction; valid while `inst_ready`. Compressed instructions are already expanded by `memctrl`.
- `is_c` out 1: instruction was 16-bit; valid while `inst_ready`.
- `mem_if_enable` out 1: miss request to `memctrl`, level.
- `mem_if_addr` out 32: miss PC.
- `mem_if_ready` in 1: `memctrl` one-cycle completion pulse.
- `mem_inst` in 32: instruction from `memctrl`.
- `mem_is_c` in 1: compressed flag from `memctrl`.

## Operation
- Storage per entry: `valid`, tag (32-INDEX_WIDTH-1 bits), `inst[31:0]`, `is_c`.
- FSM states:
  - IDLE: sample `if_enable`. On a hit, load `inst_val`/`is_c` from the entry, set `inst_ready`<=1 and go to RESP. On a miss, set `mem_if_enable`<=1 and `mem_if_addr`<=`if_addr`, latch `if_addr` into `miss_addr`, and go to MISS.
  - MISS: wait for `mem_if_ready`. On it: write the entry at `miss_addr`'s index (valid=1, tag, `mem_inst`, `mem_is_c`); drive `inst_val`<=`mem_inst`, `is_c`<=`mem_is_c`, `inst_ready`<=1; set `mem_if_enable`<=0; go to RESP.
  - RESP: `inst_ready`<=0 and go to IDLE. `if_enable` is ignored in this state because the decoder's stale request is still visible.
- `clear` (has priority over everything except reset): go to IDLE; `inst_ready`<=0; `mem_if_enable`<=0. A fill whose `mem_if_ready` coincides with `clear` is discarded and the array is not written. Valid bits are kept, since code is never self-modified.
- `rdy_in` low: no state, array, or output register changes. Pulses stretch until `rdy_in` returns.
- Reset: all valid bits cleared, state IDLE. Reset mid-miss abandons the miss.
- Reset values: `inst_ready`=0, `inst_val`=0, `is_c`=0, `mem_if_enable`=0, `mem_if_addr`=0.

## Timing
- Hit: `if_enable` sampled at edge t, `inst_ready` high for cycle t..t+1. The next request is accepted at edge t+2.
- Miss: `mem_if_enable` rises one cycle after request sampling. `inst_ready` rises one cycle after the edge sampling `mem_if_ready`. Total latency = `memctrl` latency + 2.
- `mem_if_enable` deasserts at the same edge that samples `mem_if_ready`. `memctrl` must not start a new fetch in the cycle its ready pulse is high.
- Lookup is combinational from the array plus a registered response. No same-cycle bypass of a fill into a new lookup is needed, because RESP separates them.
- A conflicting tag at the same index overwrites the entry (no replacement policy).

## Structure
- Shared defines header: `ICACHE_INDEX_WIDTH` and derived `ICACHE_TAG_WIDTH`, next to `ROB_WIDTH`. FSM state encodings stay local.
- One sub-module, `icache_array`: entry storage with one combinational read port and one synchronous write port, plus a reset that clears valid bits. The FSM and handshakes live in `icache`.
- Instantiated in `cpu` between `dec0`'s `if_enable`/`if_addr`/`inst_ready`/`inst_val`/`is_c` and `mc0`'s `if_*`/`inst`/`is_c` ports.

## Test plan
- Cold miss: request 0x00000000; `memctrl` model returns 0x00000513, `is_c`=0 after 4 cycles. Expect `mem_if_addr`=0 and `inst_ready` with 0x00000513 exactly one cycle after `mem_if_ready`.
- Hit: after the cold miss, request 0x00000000 again. Expect `inst_ready` one cycle after request with 0x00000513, and `mem_if_enable` stays 0.
- Compressed and alias: fetch 0x00000002 (returned `is_c`=1, 0x00004501), then 0x00000082 (aliases index 1 when INDEX_WIDTH=6), then 0x00000002 again. Expect the third fetch to miss and re-fetch, and `is_c`=1 on the first and third responses.
- Clear in MISS: assert `clear` in the same cycle as `mem_if_ready`. Expect no `inst_ready`, `mem_if_enable`=0 next cycle, and a later fetch of the same PC to miss.
- Stall: hold `rdy_in`=0 for 3 cycles while `inst_ready`=1. Expect `inst_ready` and `inst_val` to stay constant, and exactly one response after `rdy_in` returns.
- Reset mid-miss: assert `rst_in` while `mem_if_enable`=1. Expect all outputs 0 next cycle, and the previously cached PC 0x0 to miss.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared sizing for the instruction cache and its neighbours in the core.
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH = 6;
  localparam int ICACHE_TAG_WIDTH   = 32 - ICACHE_INDEX_WIDTH - 1;
  localparam int ROB_WIDTH          = 4;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped entry storage: one combinational read port, one synchronous
// write port. Only the valid bits are reset; tag and payload need no reset
// because they are never consulted while the valid bit is clear.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 32 - INDEX_WIDTH - 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [31:0]            rd_inst,
  output logic                   rd_is_c,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [31:0]            wr_inst,
  input  logic                   wr_is_c
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_WIDTH-1:0] tag_mem  [ENTRIES];
  logic [31:0]          inst_mem [ENTRIES];
  logic                 is_c_mem [ENTRIES];

  // Valid bits: cleared by reset, set by each fill.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Payload write on fill.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      inst_mem[wr_index] <= wr_inst;
      is_c_mem[wr_index] <= wr_is_c;
    end
  end

  // Combinational read of the entry selected by the current fetch PC.
  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_tag   = tag_mem[rd_index];
    rd_inst  = inst_mem[rd_index];
    rd_is_c  = is_c_mem[rd_index];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the decoder fetch port and the
// memory controller, keyed on halfword PC so RV32C fetches cache cleanly.
//
//   state  | meaning
//   IDLE   | sample fetch request, hit -> respond, miss -> issue memory fetch
//   MISS   | waiting for memctrl completion pulse, then fill and respond
//   RESP   | response pulse in flight; stale decoder request ignored
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic [31:0] inst_val,
  output logic        is_c,
  output logic        mem_if_enable,
  output logic [31:0] mem_if_addr,
  input  logic        mem_if_ready,
  input  logic [31:0] mem_inst,
  input  logic        mem_is_c
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [31:1] miss_pc, miss_pc_nxt;
  logic        inst_ready_nxt, is_c_nxt, mem_if_enable_nxt;
  logic [31:0] inst_val_nxt, mem_if_addr_nxt;
  logic        fill;

  logic                 rd_valid, rd_is_c, hit;
  logic [TAG_WIDTH-1:0] rd_tag;
  logic [31:0]          rd_inst;

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (if_addr[INDEX_WIDTH:1]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_inst  (rd_inst),
    .rd_is_c  (rd_is_c),
    .wr_en    (fill && rdy_in),
    .wr_index (miss_pc[INDEX_WIDTH:1]),
    .wr_tag   (miss_pc[31:INDEX_WIDTH+1]),
    .wr_inst  (mem_inst),
    .wr_is_c  (mem_is_c)
  );

  assign hit = rd_valid && (rd_tag == if_addr[31:INDEX_WIDTH+1]);

  // State and output registers; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      miss_pc       <= '0;
      inst_ready    <= 1'b0;
      inst_val      <= '0;
      is_c          <= 1'b0;
      mem_if_enable <= 1'b0;
      mem_if_addr   <= '0;
    end else if (rdy_in) begin
      state         <= state_nxt;
      miss_pc       <= miss_pc_nxt;
      inst_ready    <= inst_ready_nxt;
      inst_val      <= inst_val_nxt;
      is_c          <= is_c_nxt;
      mem_if_enable <= mem_if_enable_nxt;
      mem_if_addr   <= mem_if_addr_nxt;
    end
  end

  // Next-state and next-output logic; clear drops any fill in progress.
  always_comb begin
    state_nxt         = state;
    miss_pc_nxt       = miss_pc;
    inst_ready_nxt    = inst_ready;
    inst_val_nxt      = inst_val;
    is_c_nxt          = is_c;
    mem_if_enable_nxt = mem_if_enable;
    mem_if_addr_nxt   = mem_if_addr;
    fill              = 1'b0;
    if (clear) begin
      state_nxt         = S_IDLE;
      inst_ready_nxt    = 1'b0;
      mem_if_enable_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_enable) begin
            if (hit) begin
              inst_val_nxt   = rd_inst;
              is_c_nxt       = rd_is_c;
              inst_ready_nxt = 1'b1;
              state_nxt      = S_RESP;
            end else begin
              mem_if_enable_nxt = 1'b1;
              mem_if_addr_nxt   = if_addr;
              miss_pc_nxt       = if_addr[31:1];
              state_nxt         = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mem_if_ready) begin
            fill              = 1'b1;
            inst_val_nxt      = mem_inst;
            is_c_nxt          = mem_is_c;
            inst_ready_nxt    = 1'b1;
            mem_if_enable_nxt = 1'b0;
            state_nxt         = S_RESP;
          end
        end
        S_RESP: begin
          inst_ready_nxt = 1'b0;
          state_nxt      = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: cold miss, hit, compressed/alias, clear
// during fill, stall and reset mid-miss.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, if_enable, mem_if_ready, mem_is_c;
  logic [31:0] if_addr, mem_inst;
  logic        inst_ready, is_c, mem_if_enable;
  logic [31:0] inst_val, mem_if_addr;

  int n_chk  = 0;
  int n_pass = 0;

  icache dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear         (clear),
    .if_enable     (if_enable),
    .if_addr       (if_addr),
    .inst_ready    (inst_ready),
    .inst_val      (inst_val),
    .is_c          (is_c),
    .mem_if_enable (mem_if_enable),
    .mem_if_addr   (mem_if_addr),
    .mem_if_ready  (mem_if_ready),
    .mem_inst      (mem_inst),
    .mem_is_c      (mem_is_c)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  // Request a PC that must miss; memctrl answers after lat cycles.
  task automatic fetch_miss(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic c, input int lat);
    if_enable = 1'b1;
    if_addr   = pc;
    cyc();
    chk({tag, "_men"}, {31'd0, mem_if_enable}, 32'd1);
    chk({tag, "_maddr"}, mem_if_addr, pc);
    chk({tag, "_nordy"}, {31'd0, inst_ready}, 32'd0);
    repeat (lat - 1) cyc();
    mem_if_ready = 1'b1;
    mem_inst     = inst;
    mem_is_c     = c;
    cyc();
    mem_if_ready = 1'b0;
    chk({tag, "_rdy"}, {31'd0, inst_ready}, 32'd1);
    chk({tag, "_val"}, inst_val, inst);
    chk({tag, "_isc"}, {31'd0, is_c}, {31'd0, c});
    chk({tag, "_mendrop"}, {31'd0, mem_if_enable}, 32'd0);
    if_enable = 1'b0;
    cyc();
    chk({tag, "_pulse"}, {31'd0, inst_ready}, 32'd0);
  endtask

  // Request a PC that must hit.
  task automatic fetch_hit(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic c);
    if_enable = 1'b1;
    if_addr   = pc;
    cyc();
    chk({tag, "_rdy"}, {31'd0, inst_ready}, 32'd1);
    chk({tag, "_val"}, inst_val, inst);
    chk({tag, "_isc"}, {31'd0, is_c}, {31'd0, c});
    chk({tag, "_nomem"}, {31'd0, mem_if_enable}, 32'd0);
    if_enable = 1'b0;
    cyc();
    chk({tag, "_pulse"}, {31'd0, inst_ready}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b0;
    if_addr = '0; mem_if_ready = 1'b0; mem_inst = '0; mem_is_c = 1'b0;
    cyc(); cyc();
    rst_in = 1'b0;
    chk("rst_rdy", {31'd0, inst_ready}, 32'd0);
    chk("rst_val", inst_val, 32'd0);
    chk("rst_men", {31'd0, mem_if_enable}, 32'd0);
    chk("rst_maddr", mem_if_addr, 32'd0);
    cyc();

    // Cold miss then hit on PC 0.
    fetch_miss("cold", 32'h0000_0000, 32'h0000_0513, 1'b0, 4);
    fetch_hit("hit0", 32'h0000_0000, 32'h0000_0513, 1'b0);

    // Compressed entry, aliasing PC at same index, then re-fetch.
    fetch_miss("c1", 32'h0000_0002, 32'h0000_4501, 1'b1, 3);
    fetch_hit("c1hit", 32'h0000_0002, 32'h0000_4501, 1'b1);
    fetch_miss("alias", 32'h0000_0082, 32'h00a0_0093, 1'b0, 2);
    fetch_miss("c3", 32'h0000_0002, 32'h0000_4501, 1'b1, 2);
    fetch_hit("hit0b", 32'h0000_0000, 32'h0000_0513, 1'b0);

    // Clear coinciding with the fill pulse discards the fill.
    if_enable = 1'b1;
    if_addr   = 32'h0000_0010;
    cyc();
    chk("clr_men", {31'd0, mem_if_enable}, 32'd1);
    cyc();
    mem_if_ready = 1'b1; mem_inst = 32'h1111_2222; mem_is_c = 1'b0; clear = 1'b1;
    cyc();
    mem_if_ready = 1'b0; clear = 1'b0; if_enable = 1'b0;
    chk("clr_nordy", {31'd0, inst_ready}, 32'd0);
    chk("clr_mendrop", {31'd0, mem_if_enable}, 32'd0);
    cyc();
    chk("clr_idle", {31'd0, inst_ready}, 32'd0);
    fetch_miss("clr_refetch", 32'h0000_0010, 32'h1111_2222, 1'b0, 2);

    // Stall while the response pulse is up.
    if_enable = 1'b1;
    if_addr   = 32'h0000_0000;
    cyc();
    chk("stall_rdy0", {31'd0, inst_ready}, 32'd1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_rdy", {31'd0, inst_ready}, 32'd1);
      chk("stall_val", inst_val, 32'h0000_0513);
    end
    rdy_in    = 1'b1;
    if_enable = 1'b0;
    cyc();
    chk("stall_end", {31'd0, inst_ready}, 32'd0);
    cyc();
    chk("stall_once", {31'd0, inst_ready}, 32'd0);

    // Reset while a miss is outstanding.
    if_enable = 1'b1;
    if_addr   = 32'h0000_0040;
    cyc();
    chk("rmid_men", {31'd0, mem_if_enable}, 32'd1);
    rst_in    = 1'b1;
    if_enable = 1'b0;
    cyc();
    rst_in = 1'b0;
    chk("rmid_rdy", {31'd0, inst_ready}, 32'd0);
    chk("rmid_val", inst_val, 32'd0);
    chk("rmid_isc", {31'd0, is_c}, 32'd0);
    chk("rmid_men0", {31'd0, mem_if_enable}, 32'd0);
    chk("rmid_maddr", mem_if_addr, 32'd0);
    cyc();
    fetch_miss("rmid_pc0", 32'h0000_0000, 32'h0000_0513, 1'b0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
